// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 4-bit registered arithmetic/logic unit
//
// Computes one of 16 operations on two unsigned 4-bit operands and registers
// the 8-bit result and a carry/borrow/shift-out flag on every rising clk edge.
// Latency is one cycle; a new operation is accepted every cycle.
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst       in   1  asynchronous active-high reset (clears outputs at once)
//   A         in   4  operand A, unsigned
//   B         in   4  operand B, unsigned
//   ALU_Sel   in   4  operation select (see op_e)
//   ALU_Out   out  8  registered result
//   CarryOut  out  1  registered carry (add), borrow (sub), shift-out (shl)
// ---------------------------------------------------------------------------
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] ALU_Sel,
  output logic [7:0] ALU_Out,
  output logic       CarryOut
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_SHL  = 4'h4,
    OP_SHR  = 4'h5,
    OP_ROL  = 4'h6,
    OP_ROR  = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_XOR  = 4'hA,
    OP_NOR  = 4'hB,
    OP_NAND = 4'hC,
    OP_XNOR = 4'hD,
    OP_GT   = 4'hE,
    OP_EQ   = 4'hF
  } op_e;

  op_e        op;
  logic [7:0] result;
  logic       carry;

  assign op = op_e'(ALU_Sel);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; this is what
    // keeps the combinational block from inferring latches.
    result = 8'h00;
    carry  = 1'b0;
    case (op)
      OP_ADD:  {carry, result[3:0]} = {1'b0, A} + {1'b0, B};
      // 5-bit difference: bit 4 is set exactly when A < B, i.e. the borrow.
      OP_SUB:  {carry, result[3:0]} = {1'b0, A} - {1'b0, B};
      OP_MUL:  result = {4'h0, A} * {4'h0, B};
      // Divide by zero returns all ones rather than an undefined quotient.
      OP_DIV:  result = (B == 4'h0) ? 8'hFF : {4'h0, A / B};
      OP_SHL:  {carry, result[3:0]} = {A, 1'b0};
      OP_SHR:  result[3:0] = {1'b0, A[3:1]};
      OP_ROL:  result[3:0] = {A[2:0], A[3]};
      OP_ROR:  result[3:0] = {A[0], A[3:1]};
      OP_AND:  result[3:0] = A & B;
      OP_OR:   result[3:0] = A | B;
      OP_XOR:  result[3:0] = A ^ B;
      OP_NOR:  result[3:0] = ~(A | B);
      OP_NAND: result[3:0] = ~(A & B);
      OP_XNOR: result[3:0] = ~(A ^ B);
      OP_GT:   result[0]   = (A > B);
      OP_EQ:   result[0]   = (A == B);
      default: ;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALU_Out  <= 8'h00;
      CarryOut <= 1'b0;
    end else begin
      ALU_Out  <= result;
      CarryOut <= carry;
    end
  end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu
//
// Table of directed vectors with hand-computed results, applied back to back
// one per cycle, plus hand-written reset sequences (initial reset, async
// assertion mid-cycle, hold across edges, first edge after release).
// ---------------------------------------------------------------------------
module tb_alu;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] sel;
  logic [7:0] alu_out;
  logic       carry_out;

  int checks = 0;
  int errors = 0;

  alu dut (
    .clk      (clk),
    .rst      (rst),
    .A        (a),
    .B        (b),
    .ALU_Sel  (sel),
    .ALU_Out  (alu_out),
    .CarryOut (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sel;
    logic [7:0] exp_out;
    logic       exp_c;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [7:0] exp_out, input logic exp_c);
    checks++;
    if (alu_out !== exp_out || carry_out !== exp_c) begin
      errors++;
      $display("FAIL %s: got ALU_Out=%02h CarryOut=%b, expected ALU_Out=%02h CarryOut=%b",
               name, alu_out, carry_out, exp_out, exp_c);
    end
  endtask

  // Drive on the falling edge, let the rising edge register, sample 1 ns later.
  task automatic apply(input logic [3:0] va, input logic [3:0] vb, input logic [3:0] vs);
    @(negedge clk);
    a   = va;
    b   = vb;
    sel = vs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // A=0xA, B=0x2 stepped through every select, then add last.
    vecs[0]  = '{"sub_a_2",   4'hA, 4'h2, 4'h1, 8'h08, 1'b0};
    vecs[1]  = '{"mul_a_2",   4'hA, 4'h2, 4'h2, 8'h14, 1'b0};
    vecs[2]  = '{"div_a_2",   4'hA, 4'h2, 4'h3, 8'h05, 1'b0};
    vecs[3]  = '{"shl_a",     4'hA, 4'h2, 4'h4, 8'h04, 1'b1};
    vecs[4]  = '{"shr_a",     4'hA, 4'h2, 4'h5, 8'h05, 1'b0};
    vecs[5]  = '{"rol_a",     4'hA, 4'h2, 4'h6, 8'h05, 1'b0};
    vecs[6]  = '{"ror_a",     4'hA, 4'h2, 4'h7, 8'h05, 1'b0};
    vecs[7]  = '{"and_a_2",   4'hA, 4'h2, 4'h8, 8'h02, 1'b0};
    vecs[8]  = '{"or_a_2",    4'hA, 4'h2, 4'h9, 8'h0A, 1'b0};
    vecs[9]  = '{"xor_a_2",   4'hA, 4'h2, 4'hA, 8'h08, 1'b0};
    vecs[10] = '{"nor_a_2",   4'hA, 4'h2, 4'hB, 8'h05, 1'b0};
    vecs[11] = '{"nand_a_2",  4'hA, 4'h2, 4'hC, 8'h0D, 1'b0};
    vecs[12] = '{"xnor_a_2",  4'hA, 4'h2, 4'hD, 8'h07, 1'b0};
    vecs[13] = '{"gt_a_2",    4'hA, 4'h2, 4'hE, 8'h01, 1'b0};
    vecs[14] = '{"eq_a_2",    4'hA, 4'h2, 4'hF, 8'h00, 1'b0};
    vecs[15] = '{"add_a_2",   4'hA, 4'h2, 4'h0, 8'h0C, 1'b0};
    // Boundaries: add overflow, max product, borrow, divide by zero.
    vecs[16] = '{"add_ovf",   4'hF, 4'h1, 4'h0, 8'h00, 1'b1};
    vecs[17] = '{"mul_max",   4'hF, 4'hF, 4'h2, 8'hE1, 1'b0};
    vecs[18] = '{"sub_borrow",4'h2, 4'h5, 4'h1, 8'h0D, 1'b1};
    vecs[19] = '{"div_zero",  4'h7, 4'h0, 4'h3, 8'hFF, 1'b0};
    vecs[20] = '{"div_7_2",   4'h7, 4'h2, 4'h3, 8'h03, 1'b0};
    // Comparators at equality and at the extremes.
    vecs[21] = '{"eq_9_9",    4'h9, 4'h9, 4'hF, 8'h01, 1'b0};
    vecs[22] = '{"gt_9_9",    4'h9, 4'h9, 4'hE, 8'h00, 1'b0};
    vecs[23] = '{"gt_0_f",    4'h0, 4'hF, 4'hE, 8'h00, 1'b0};

    // Reset held from time zero with live inputs: outputs must stay clear.
    rst = 1'b1;
    a   = 4'hF;
    b   = 4'hF;
    sel = 4'h2;
    #3;
    check("reset_initial", 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held_edge", 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].sel);
      check(vecs[i].name, vecs[i].exp_out, vecs[i].exp_c);
    end

    // Async reset mid-cycle while ALU_Out holds 0x14.
    apply(4'hA, 4'h2, 4'h2);
    check("pre_reset_mul", 8'h14, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_clear", 8'h00, 1'b0);
    // Inputs during reset would give nonzero results; they must be discarded.
    a   = 4'hF;
    b   = 4'h1;
    sel = 4'h0;
    @(posedge clk);
    #1;
    check("reset_hold_edge1", 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check("reset_hold_edge2", 8'h00, 1'b0);

    // First edge after release registers normally.
    @(negedge clk);
    rst = 1'b0;
    apply(4'hF, 4'h1, 4'h0);
    check("post_reset_add", 8'h00, 1'b1);
    apply(4'h8, 4'h0, 4'h4);
    check("post_reset_shl", 8'h00, 1'b1);
    apply(4'h3, 4'h4, 4'h2);
    check("post_reset_mul", 8'h0C, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
